// File: rtl/ysyx_24100006_ifu_pkg.sv
// Shared types and constants for the ysyx_24100006 instruction fetch unit.
package ysyx_24100006_ifu_pkg;

    localparam int unsigned XLEN    = 32;
    localparam int unsigned STATE_W = 3;
    localparam int unsigned RESP_W  = 2;

    typedef enum logic [STATE_W-1:0] {
        S_REQ      = 3'd0,
        S_WAIT_R   = 3'd1,
        S_HOLD     = 3'd2,
        S_WAIT_NPC = 3'd3,
        S_ERR      = 3'd4
    } ifu_state_e;

    localparam logic [RESP_W-1:0] RESP_OKAY        = 2'b00;
    localparam logic [XLEN-1:0]   DEFAULT_RESET_PC = 32'h8000_0000;

    // Instruction fetches must be word aligned.
    function automatic logic is_word_aligned(input logic [XLEN-1:0] addr);
        return addr[1:0] == 2'b00;
    endfunction

endpackage

// File: rtl/ysyx_24100006_pc_reg.sv
// Architectural PC register: async reset to RESET_PC, loads pc_d when load is high.
module ysyx_24100006_pc_reg
    import ysyx_24100006_ifu_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load,
    input  logic [XLEN-1:0] pc_d,
    output logic [XLEN-1:0] pc_q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= RESET_PC;
        end else if (load) begin
            pc_q <= pc_d;
        end
    end

endmodule

// File: rtl/ysyx_24100006_ifu.sv
// Multi-cycle instruction fetch unit: one AR/R read per instruction, hand-off to
// decode over valid/ready, then wait for the next PC from EX.
module ysyx_24100006_ifu
    import ysyx_24100006_ifu_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [XLEN-1:0]   npc,
    input  logic              npc_valid,
    output logic [XLEN-1:0]   araddr,
    output logic              arvalid,
    input  logic              arready,
    input  logic [XLEN-1:0]   rdata,
    input  logic [RESP_W-1:0] rresp,
    input  logic              rvalid,
    output logic              rready,
    output logic [XLEN-1:0]   inst,
    output logic [XLEN-1:0]   inst_pc,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic              fetch_err,
    output logic [XLEN-1:0]   err_pc
);

    ifu_state_e      state_q;
    ifu_state_e      state_d;
    logic [XLEN-1:0] pc_q;
    logic            pc_load;
    logic [XLEN-1:0] inst_q;
    logic [XLEN-1:0] inst_d;
    logic [XLEN-1:0] err_pc_q;
    logic [XLEN-1:0] err_pc_d;

    ysyx_24100006_pc_reg #(
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (pc_load),
        .pc_d  (npc),
        .pc_q  (pc_q)
    );

    // State and fetch-result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_REQ;
            inst_q   <= '0;
            err_pc_q <= '0;
        end else begin
            state_q  <= state_d;
            inst_q   <= inst_d;
            err_pc_q <= err_pc_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_REQ: begin
                if (arready) state_d = S_WAIT_R;
            end
            S_WAIT_R: begin
                if (rvalid) state_d = (rresp == RESP_OKAY) ? S_HOLD : S_ERR;
            end
            S_HOLD: begin
                if (inst_ready) state_d = S_WAIT_NPC;
            end
            S_WAIT_NPC: begin
                if (npc_valid) state_d = is_word_aligned(npc) ? S_REQ : S_ERR;
            end
            S_ERR: begin
                state_d = S_ERR;
            end
            default: begin
                state_d = S_ERR;
            end
        endcase
    end

    // Handshake decodes and datapath register updates.
    always_comb begin
        arvalid   = 1'b0;
        rready    = 1'b0;
        inst_valid = 1'b0;
        fetch_err = 1'b0;
        pc_load   = 1'b0;
        inst_d    = inst_q;
        err_pc_d  = err_pc_q;
        unique case (state_q)
            S_REQ: begin
                arvalid = 1'b1;
            end
            S_WAIT_R: begin
                rready = 1'b1;
                if (rvalid) begin
                    if (rresp == RESP_OKAY) inst_d = rdata;
                    else                    err_pc_d = pc_q;
                end
            end
            S_HOLD: begin
                inst_valid = 1'b1;
            end
            S_WAIT_NPC: begin
                if (npc_valid) begin
                    pc_load = 1'b1;
                    if (!is_word_aligned(npc)) err_pc_d = npc;
                end
            end
            S_ERR: begin
                fetch_err = 1'b1;
            end
            default: begin
                fetch_err = 1'b1;
            end
        endcase
    end

    assign araddr  = pc_q;
    assign inst_pc = pc_q;
    assign inst    = inst_q;
    assign err_pc  = err_pc_q;

endmodule

// File: tb/tb_ysyx_24100006_ifu.sv
// Directed self-checking bench for ysyx_24100006_ifu with a fetch scoreboard.
module tb_ysyx_24100006_ifu;

    localparam logic [31:0] RST_PC = 32'h8000_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] word;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] npc = '0;
    logic        npc_valid = 1'b0;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready = 1'b0;
    logic [31:0] rdata = '0;
    logic [1:0]  rresp = '0;
    logic        rvalid = 1'b0;
    logic        rready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic        fetch_err;
    logic [31:0] err_pc;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;
    logic [31:0] exp_pc = RST_PC;
    exp_t        sb_q[$];

    ysyx_24100006_ifu #(.RESET_PC(RST_PC)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .npc        (npc),
        .npc_valid  (npc_valid),
        .araddr     (araddr),
        .arvalid    (arvalid),
        .arready    (arready),
        .rdata      (rdata),
        .rresp      (rresp),
        .rvalid     (rvalid),
        .rready     (rready),
        .inst       (inst),
        .inst_pc    (inst_pc),
        .inst_valid (inst_valid),
        .inst_ready (inst_ready),
        .fetch_err  (fetch_err),
        .err_pc     (err_pc)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_arvalid"}, 32'(arvalid), 32'd0);
        check({tag, "_rready"}, 32'(rready), 32'd0);
        check({tag, "_inst_valid"}, 32'(inst_valid), 32'd0);
    endtask

    // Assert reset asynchronously, check reset values, release after one edge.
    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check("rst_arvalid", 32'(arvalid), 32'd1);
        check("rst_rready", 32'(rready), 32'd0);
        check("rst_inst_valid", 32'(inst_valid), 32'd0);
        check("rst_fetch_err", 32'(fetch_err), 32'd0);
        check("rst_inst", inst, 32'd0);
        check("rst_err_pc", err_pc, 32'd0);
        check("rst_inst_pc", inst_pc, RST_PC);
        tick();
        rst_n = 1'b1;
        exp_pc = RST_PC;
        sb_q.delete();
    endtask

    // One read transaction with arw stall cycles on AR and rw on R.
    task automatic do_fetch(input int arw, input int rw, input logic [31:0] data, input logic [1:0] resp);
        for (int i = 0; i < arw; i++) begin
            check("ar_wait_arvalid", 32'(arvalid), 32'd1);
            check("ar_wait_araddr", araddr, exp_pc);
            tick();
        end
        check("ar_arvalid", 32'(arvalid), 32'd1);
        check("ar_araddr", araddr, exp_pc);
        arready = 1'b1;
        tick();
        arready = 1'b0;
        for (int i = 0; i < rw; i++) begin
            check("r_wait_rready", 32'(rready), 32'd1);
            check("r_wait_arvalid", 32'(arvalid), 32'd0);
            tick();
        end
        check("r_rready", 32'(rready), 32'd1);
        rvalid = 1'b1;
        rdata  = data;
        rresp  = resp;
        if (resp == 2'b00) sb_q.push_back('{pc: exp_pc, word: data});
        tick();
        rvalid = 1'b0;
        rdata  = $urandom;
        rresp  = 2'b00;
    endtask

    // Decode hand-off with bp cycles of back-pressure; optionally poke npc_valid in HOLD.
    task automatic accept(input int bp, input bit poke_npc);
        exp_t e;
        check("sb_nonempty", 32'(sb_q.size()), 32'd1);
        e = (sb_q.size() != 0) ? sb_q[0] : '0;
        for (int i = 0; i < bp; i++) begin
            check("hold_inst_valid", 32'(inst_valid), 32'd1);
            check("hold_inst", inst, e.word);
            check("hold_inst_pc", inst_pc, e.pc);
            check("hold_arvalid", 32'(arvalid), 32'd0);
            if (poke_npc && i == 1) begin
                npc_valid = 1'b1;
                npc = 32'h8000_0100;
            end
            tick();
            npc_valid = 1'b0;
        end
        check("xfer_inst_valid", 32'(inst_valid), 32'd1);
        check("xfer_inst", inst, e.word);
        check("xfer_inst_pc", inst_pc, e.pc);
        inst_ready = 1'b1;
        if (sb_q.size() != 0) void'(sb_q.pop_front());
        tick();
        inst_ready = 1'b0;
        check("post_xfer_inst_valid", 32'(inst_valid), 32'd0);
    endtask

    task automatic send_npc(input logic [31:0] v);
        check_idle_outputs("wait_npc");
        npc_valid = 1'b1;
        npc = v;
        tick();
        npc_valid = 1'b0;
        exp_pc = v;
    endtask

    task automatic check_err(input logic [31:0] epc);
        for (int i = 0; i < 3; i++) begin
            check("err_fetch_err", 32'(fetch_err), 32'd1);
            check("err_err_pc", err_pc, epc);
            check_idle_outputs("err");
            if (i == 0) begin
                npc_valid = 1'b1;
                npc = RST_PC;
            end
            tick();
            npc_valid = 1'b0;
        end
    endtask

    initial begin
        tick();
        do_reset();

        // Zero-wait fetch, back-pressure, ignored npc during HOLD.
        do_fetch(0, 0, 32'h0000_0413, 2'b00);
        accept(5, 1'b1);
        check("wait_npc_pc", inst_pc, RST_PC);
        tick();
        check_idle_outputs("wait_npc_idle");
        send_npc(32'h8000_0010);
        check("npc_arvalid", 32'(arvalid), 32'd1);
        check("npc_araddr", araddr, 32'h8000_0010);

        // Slow memory: stable request, exactly one transfer.
        do_fetch(3, 4, 32'hdead_beef, 2'b00);
        accept(0, 1'b0);
        tick();
        check("single_xfer_inst_valid", 32'(inst_valid), 32'd0);

        // Read error response.
        send_npc(32'h8000_0020);
        do_fetch(1, 0, 32'h1234_5678, 2'b10);
        check_err(32'h8000_0020);

        // Misaligned next PC.
        do_reset();
        do_fetch(0, 1, 32'h0010_0093, 2'b00);
        accept(2, 1'b0);
        send_npc(32'h8000_0006);
        check_err(32'h8000_0006);

        // Reset in WAIT_R with a late rvalid.
        do_reset();
        do_fetch(0, 0, 32'h0020_0113, 2'b00);
        accept(0, 1'b0);
        send_npc(32'h8000_0040);
        check("pre_abort_araddr", araddr, 32'h8000_0040);
        arready = 1'b1;
        tick();
        arready = 1'b0;
        check("abort_rready", 32'(rready), 32'd1);
        rvalid = 1'b1;
        rdata = 32'hbad0_bad0;
        do_reset();
        check("late_r_rready", 32'(rready), 32'd0);
        check("late_r_arvalid", 32'(arvalid), 32'd1);
        tick();
        rvalid = 1'b0;
        check("late_r_inst", inst, 32'd0);
        check("late_r_inst_valid", 32'(inst_valid), 32'd0);
        do_fetch(0, 0, 32'h0030_0193, 2'b00);
        accept(1, 1'b0);
        check("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ysyx_24100006_ifu.md
# ysyx_24100006_ifu

Instruction fetch unit for the multi-cycle ysyx_24100006 core. Holds the architectural PC, issues one read per instruction on a simplified AR/R memory handshake, and presents the fetched word with its PC to the decode stage over a valid/ready handshake. It then waits for the execute stage's next-PC result (`npc`, `npc_valid`) before fetching again. Instruction memory sits on the downstream side of the read handshake; the next-PC logic in EX sits on the upstream side of `npc`.

## Interface
- `RESET_PC`, default 32'h8000_0000: PC value loaded on reset; must be 4-byte aligned.
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `npc`  in  32: next PC produced by EX.
- `npc_valid`  in  1: one-cycle strobe; `npc` is valid.
- `araddr`  out  32: fetch address; always equals the current PC.
- `arvalid`  out  1: read request valid.
- `arready`  in  1: memory accepts the request.
- `rdata`  in  32: read data.
- `rresp`  in  2: response code; 2'b00 = OKAY, anything else = error.
- `rvalid`  in  1: read response valid.
- `rready`  out  1: IFU accepts the response.
- `inst`  out  32: fetched instruction, registered.
- `inst_pc`  out  32: PC of `inst`.
- `inst_valid`  out  1: `inst`/`inst_pc` valid for decode.
- `inst_ready`  in  1: decode accepts the instruction.
- `fetch_err`  out  1: sticky fetch fault flag.
- `err_pc`  out  32: PC that caused the fault.

## Operation
- States: REQ, WAIT_R, HOLD, WAIT_NPC, ERR.
- REQ: `arvalid`=1, `araddr`=pc. On `arready`, go to WAIT_R. `arvalid` and `araddr` stay stable until the handshake completes.
- WAIT_R: `rready`=1. On `rvalid`:
  - `rresp`==OKAY: latch `rdata` into `inst`, go to HOLD.
  - any other `rresp`: `err_pc`<=pc, go to ERR.
- HOLD: `inst_valid`=1. On `inst_ready`, go to WAIT_NPC. `inst` and `inst_pc` stay stable while held.
- WAIT_NPC: on `npc_valid`, `pc`<=`npc`.
  - `npc[1:0]`==0: go to REQ.
  - otherwise: `err_pc`<=`npc`, go to ERR. No request is issued.
- ERR: all handshake outputs are 0 and `fetch_err`=1. The only exit is reset.
- `npc_valid` in any state other than WAIT_NPC is ignored. The PC is unchanged and no error is raised.
- `rvalid` outside WAIT_R is ignored, because `rready`=0 there.
- `inst_pc` always equals pc. The PC changes only in WAIT_NPC.

## Timing
- Reset values: state=REQ, pc=`RESET_PC`, `inst`=0, `err_pc`=0, `inst_valid`=`rready`=`fetch_err`=0.
  - `arvalid` is decoded from state, so it is 1 while reset is held and in the first cycle after reset deasserts.
- Asserting `rst_n` mid-transaction aborts the fetch immediately. A late `rvalid` after reset is never consumed.
- Minimum latency with zero-wait memory (`arready`=1, `rvalid` the following cycle):
  - cycle 0: `arvalid`
  - cycle 1: `rready`
  - cycle 2: `inst_valid`
  - cycle 3 (with `inst_ready`): WAIT_NPC
  - next REQ: the cycle after `npc_valid`.
- All handshake outputs are pure decodes of the state register; there are no combinational input-to-output paths.
- Back-pressure on `inst_ready` holds HOLD for any number of cycles.

## Structure
- Package `ysyx_24100006_ifu_pkg` holds:
  - the state encoding, 3-bit, as constants;
  - `RESP_OKAY`=2'b00;
  - the default `RESET_PC`.
- One sub-module is natural: `ysyx_24100006_pc_reg`, a 32-bit PC register with async active-low reset to `RESET_PC` and a load enable.
- The FSM and the `inst`/`err_pc` registers live in the top module.

## Test plan
- Reset then zero-wait memory returning 32'h0000_0413 with OKAY -> `araddr`=32'h8000_0000, `inst_valid` in cycle 2, `inst`=32'h0000_0413, `inst_pc`=32'h8000_0000.
- `inst_ready` held low for 5 cycles -> `inst`/`inst_pc` unchanged; no new `arvalid`. `npc_valid` pulsed during HOLD with `npc`=32'h8000_0100 -> ignored; pc still 32'h8000_0000.
- In WAIT_NPC, `npc_valid` with `npc`=32'h8000_0010 -> next cycle `arvalid`=1, `araddr`=32'h8000_0010.
- `arready` delayed 3 cycles, `rvalid` delayed 4 cycles -> `arvalid`/`araddr` stable throughout; exactly one `inst_valid` transfer.
- `rresp`=2'b10 -> `fetch_err`=1, `err_pc`=faulting PC, `arvalid` stays 0. `npc`=32'h8000_0006 -> ERR with `err_pc`=32'h8000_0006 and no request issued.
- `rst_n` asserted while in WAIT_R, `rvalid` arriving during reset -> outputs at reset values; the fetch restarts at `RESET_PC`.
